// File: rtl/iob_ethmac_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : iob_ethmac_arbiter
// Description : Round-robin arbiter that lets two IOb requesters share one
//               downstream IOb master port. Only one transaction is in flight
//               at a time. A slave that does not answer within TIMEOUT busy
//               cycles is aborted, and the requester gets an error response.
// Revision    : 1.0 - initial release
//==============================================================================
module iob_ethmac_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    // requester 0 (TX descriptor / DMA fetch)
    input  logic                  r0_valid_i,
    input  logic [ADDR_W-1:0]     r0_addr_i,
    input  logic [DATA_W-1:0]     r0_wdata_i,
    input  logic [DATA_W/8-1:0]   r0_wstrb_i,
    output logic [DATA_W-1:0]     r0_rdata_o,
    output logic                  r0_ready_o,
    output logic                  r0_err_o,
    // requester 1 (RX DMA write)
    input  logic                  r1_valid_i,
    input  logic [ADDR_W-1:0]     r1_addr_i,
    input  logic [DATA_W-1:0]     r1_wdata_i,
    input  logic [DATA_W/8-1:0]   r1_wstrb_i,
    output logic [DATA_W-1:0]     r1_rdata_o,
    output logic                  r1_ready_o,
    output logic                  r1_err_o,
    // shared downstream port
    output logic                  m_valid_o,
    output logic [ADDR_W-1:0]     m_addr_o,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic                  m_ready_i,
    input  logic                  m_err_i,
    // status
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    // Terminal count: the abort fires when tcnt reaches TIMEOUT-1 during a
    // busy cycle, i.e. on the TIMEOUT-th busy cycle.
    localparam logic [TIMEOUT_W-1:0] C_TLIM = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] C_TMAX = '1;
    localparam logic                 C_TMO_EN = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_grant;
    logic [1:0]           w_grant_nxt;
    logic                 r_prio;
    logic                 w_prio_nxt;
    logic [TIMEOUT_W-1:0] r_tcnt;
    logic [TIMEOUT_W-1:0] w_tcnt_nxt;

    logic                 w_busy;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_end;

    assign w_busy  = (r_state == S_BUSY);
    assign w_done  = w_busy & m_ready_i;
    // A completion in the same cycle as the terminal count takes precedence.
    assign w_abort = C_TMO_EN & w_busy & ~m_ready_i & (r_tcnt == C_TLIM);
    assign w_end   = w_done | w_abort;

    // State, owner, priority and timeout counter registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_prio  <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Arbitration in IDLE; completion / abort / counting in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            S_IDLE: begin
                if (r0_valid_i && (!r1_valid_i || !r_prio)) begin
                    w_grant_nxt = 2'b01;
                    w_state_nxt = S_BUSY;
                    w_tcnt_nxt  = '0;
                end else if (r1_valid_i) begin
                    w_grant_nxt = 2'b10;
                    w_state_nxt = S_BUSY;
                    w_tcnt_nxt  = '0;
                end
            end
            S_BUSY: begin
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 2'b00;
                    // Favour whichever requester was not just served.
                    w_prio_nxt  = r_grant[0];
                end else if (r_tcnt != C_TMAX) begin
                    w_tcnt_nxt  = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // Downstream request muxed from the owner; zero when nobody owns the port.
    always_comb begin
        m_valid_o = w_busy;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        if (r_grant[0]) begin
            m_addr_o  = r0_addr_i;
            m_wdata_o = r0_wdata_i;
            m_wstrb_o = r0_wstrb_i;
        end else if (r_grant[1]) begin
            m_addr_o  = r1_addr_i;
            m_wdata_o = r1_wdata_i;
            m_wstrb_o = r1_wstrb_i;
        end
    end

    // Responses route only to the owner; an abort returns err=1 and rdata=0.
    always_comb begin
        r0_ready_o = r_grant[0] & w_end;
        r1_ready_o = r_grant[1] & w_end;
        r0_err_o   = r_grant[0] & (w_done ? m_err_i : w_abort);
        r1_err_o   = r_grant[1] & (w_done ? m_err_i : w_abort);
        r0_rdata_o = (r_grant[0] & w_done) ? m_rdata_i : '0;
        r1_rdata_o = (r_grant[1] & w_done) ? m_rdata_i : '0;
        grant_o    = r_grant;
        timeout_o  = w_abort;
    end

    logic [STRB_W-1:0] w_strb_unused;
    assign w_strb_unused = '0;

endmodule
`default_nettype wire

// File: tb/tb_iob_ethmac_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_iob_ethmac_arbiter
// Description : Randomised scoreboard bench for iob_ethmac_arbiter. A
//               transaction-level model predicts which requester owns each
//               downstream transaction and what response it must receive.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_iob_ethmac_arbiter;

    localparam int unsigned C_AW  = 32;
    localparam int unsigned C_DW  = 32;
    localparam int unsigned C_SW  = C_DW / 8;
    localparam int unsigned C_TMO = 4;
    localparam int          C_CYCLES = 3000;

    logic              clk_i;
    logic              arst_n_i;
    logic              r0_valid_i, r1_valid_i;
    logic [C_AW-1:0]   r0_addr_i, r1_addr_i;
    logic [C_DW-1:0]   r0_wdata_i, r1_wdata_i;
    logic [C_SW-1:0]   r0_wstrb_i, r1_wstrb_i;
    logic [C_DW-1:0]   r0_rdata_o, r1_rdata_o;
    logic              r0_ready_o, r1_ready_o;
    logic              r0_err_o, r1_err_o;
    logic              m_valid_o;
    logic [C_AW-1:0]   m_addr_o;
    logic [C_DW-1:0]   m_wdata_o;
    logic [C_SW-1:0]   m_wstrb_o;
    logic [C_DW-1:0]   m_rdata_i;
    logic              m_ready_i;
    logic              m_err_i;
    logic [1:0]        grant_o;
    logic              timeout_o;

    iob_ethmac_arbiter #(
        .ADDR_W    (C_AW),
        .DATA_W    (C_DW),
        .TIMEOUT_W (8),
        .TIMEOUT   (C_TMO)
    ) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .r0_valid_i (r0_valid_i),
        .r0_addr_i  (r0_addr_i),
        .r0_wdata_i (r0_wdata_i),
        .r0_wstrb_i (r0_wstrb_i),
        .r0_rdata_o (r0_rdata_o),
        .r0_ready_o (r0_ready_o),
        .r0_err_o   (r0_err_o),
        .r1_valid_i (r1_valid_i),
        .r1_addr_i  (r1_addr_i),
        .r1_wdata_i (r1_wdata_i),
        .r1_wstrb_i (r1_wstrb_i),
        .r1_rdata_o (r1_rdata_o),
        .r1_ready_o (r1_ready_o),
        .r1_err_o   (r1_err_o),
        .m_valid_o  (m_valid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_rdata_i  (m_rdata_i),
        .m_ready_i  (m_ready_i),
        .m_err_i    (m_err_i),
        .grant_o    (grant_o),
        .timeout_o  (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            who;
        logic [C_AW-1:0] addr;
        logic [C_DW-1:0] wdata;
        logic [C_SW-1:0] wstrb;
    } bus_t;

    typedef struct {
        logic            who;
        logic [C_DW-1:0] rdata;
        logic            err;
        logic            to;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    int checks;
    int errors;

    // Transaction-level model state
    logic            mdl_busy;
    logic            owner;
    logic            fav;
    logic            prev_end;
    logic            late_flag;
    int              bc;
    int              lat;
    int              txn_idx;
    logic            cur_err;
    logic            cur_dead;
    logic            pend [2];
    logic            v    [2];
    logic [C_AW-1:0] a    [2];
    logic [C_DW-1:0] d    [2];
    logic [C_SW-1:0] s    [2];
    logic            rst_done;
    logic            prev_mv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        r0_valid_i = v[0]; r0_addr_i = a[0]; r0_wdata_i = d[0]; r0_wstrb_i = s[0];
        r1_valid_i = v[1]; r1_addr_i = a[1]; r1_wdata_i = d[1]; r1_wstrb_i = s[1];
    endtask

    task automatic new_req(input int n);
        pend[n] = 1'b1;
        v[n]    = 1'b1;
        a[n]    = $urandom;
        d[n]    = $urandom;
        s[n]    = ($urandom_range(0, 1) == 0) ? '0 : C_SW'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mvalid"}, 64'(m_valid_o), 64'd0);
        chk({tag, "_mbus"}, 64'(m_addr_o | m_wdata_o | 32'(m_wstrb_o)), 64'd0);
        chk({tag, "_grant"}, 64'(grant_o), 64'd0);
        chk({tag, "_rsp"}, 64'({r0_ready_o, r1_ready_o, r0_err_o, r1_err_o, timeout_o}), 64'd0);
        chk({tag, "_rdata"}, 64'(r0_rdata_o | r1_rdata_o), 64'd0);
    endtask

    // Monitor: compares the DUT against queued expectations on the falling edge.
    always @(negedge clk_i) begin
        resp_t r;
        bus_t  b;
        chk("m_valid", 64'(m_valid_o), 64'(mdl_busy));
        if (m_valid_o && !prev_mv) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 64'(m_valid_o), 64'd0);
            end else begin
                b = bus_q.pop_front();
                chk("grant", 64'(grant_o), b.who ? 64'd2 : 64'd1);
                chk("m_addr", 64'(m_addr_o), 64'(b.addr));
                chk("m_wdata", 64'(m_wdata_o), 64'(b.wdata));
                chk("m_wstrb", 64'(m_wstrb_o), 64'(b.wstrb));
            end
        end
        if (!m_valid_o) begin
            chk("idle_grant", 64'(grant_o), 64'd0);
            chk("idle_bus", 64'(m_addr_o | m_wdata_o | 32'(m_wstrb_o)), 64'd0);
        end
        if (r0_ready_o || r1_ready_o || timeout_o) begin
            if (resp_q.size() == 0) begin
                chk("spurious_ready", 64'({r0_ready_o, r1_ready_o, timeout_o}), 64'd0);
            end else begin
                r = resp_q.pop_front();
                chk("ready_vec", 64'({r1_ready_o, r0_ready_o}), r.who ? 64'd2 : 64'd1);
                chk("timeout", 64'(timeout_o), 64'(r.to));
                if (r.who) begin
                    chk("r1_rdata", 64'(r1_rdata_o), 64'(r.rdata));
                    chk("r1_err", 64'(r1_err_o), 64'(r.err));
                    chk("r0_quiet", 64'({r0_err_o, r0_rdata_o}), 64'd0);
                end else begin
                    chk("r0_rdata", 64'(r0_rdata_o), 64'(r.rdata));
                    chk("r0_err", 64'(r0_err_o), 64'(r.err));
                    chk("r1_quiet", 64'({r1_err_o, r1_rdata_o}), 64'd0);
                end
            end
        end
        prev_mv = m_valid_o;
    end

    // Stimulus: requesters, slave responder and the reference model.
    initial begin
        resp_t r;
        bus_t  b;
        checks = 0; errors = 0;
        mdl_busy = 1'b0; owner = 1'b0; fav = 1'b0; prev_end = 1'b0; late_flag = 1'b0;
        bc = 0; lat = 1; txn_idx = 0; cur_err = 1'b0; cur_dead = 1'b0;
        rst_done = 1'b0; prev_mv = 1'b0;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; v[n] = 1'b0; a[n] = '0; d[n] = '0; s[n] = '0;
        end
        arst_n_i = 1'b0;
        m_ready_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;
        drive_reqs();
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk_i);
        #1;
        // Both requesters contend right out of reset.
        pend[0] = 1'b1; v[0] = 1'b1; a[0] = 32'h100; d[0] = 32'h0; s[0] = 4'b0000;
        pend[1] = 1'b1; v[1] = 1'b1; a[1] = 32'h200; d[1] = 32'h11223344; s[1] = 4'b0101;
        drive_reqs();
        arst_n_i = 1'b1;

        for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
            @(posedge clk_i);
            #1;
            // Advance the model across the edge that just happened.
            if (prev_end) begin
                mdl_busy = 1'b0;
                fav      = ~owner;
                pend[owner] = 1'b0;
                v[owner]    = 1'b0;
                prev_end = 1'b0;
            end else if (!mdl_busy && (v[0] || v[1])) begin
                owner    = (v[0] && v[1]) ? fav : (v[0] ? 1'b0 : 1'b1);
                mdl_busy = 1'b1;
                bc       = 0;
                cur_dead = 1'b0;
                case (txn_idx)
                    0: begin lat = 3; cur_err = 1'b0; cur_dead = 1'b1; end
                    1: begin lat = 2; cur_err = 1'b1; end
                    2: begin lat = 6; cur_err = 1'b0; end
                    3: begin lat = 4; cur_err = 1'b0; end
                    default: begin lat = $urandom_range(1, 6); cur_err = ($urandom_range(0, 3) == 0); end
                endcase
                b.who = owner; b.addr = a[owner]; b.wdata = d[owner]; b.wstrb = s[owner];
                bus_q.push_back(b);
                txn_idx++;
            end

            // Abort a transaction mid-flight with an asynchronous reset.
            if (!rst_done && cyc >= 1500 && mdl_busy && bc >= 1) begin
                rst_done  = 1'b1;
                arst_n_i  = 1'b0;
                m_ready_i = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                mdl_busy = 1'b0; fav = 1'b0; prev_end = 1'b0; late_flag = 1'b0;
                for (int n = 0; n < 2; n++) begin
                    pend[n] = 1'b0; v[n] = 1'b0;
                end
                drive_reqs();
                @(posedge clk_i);
                #1;
                chk_all_zero("rst_hold");
                new_req(1);
                drive_reqs();
                arst_n_i = 1'b1;
                continue;
            end

            // Slave responder.
            m_ready_i = 1'b0;
            m_err_i   = 1'b0;
            m_rdata_i = $urandom;
            if (mdl_busy) begin
                bc++;
                if (bc == lat) begin
                    m_ready_i = 1'b1;
                    m_err_i   = cur_err;
                    if (cur_dead) m_rdata_i = 32'hDEADBEEF;
                    r.who = owner; r.rdata = m_rdata_i; r.err = cur_err; r.to = 1'b0;
                    resp_q.push_back(r);
                    prev_end = 1'b1;
                end else if (bc == C_TMO) begin
                    r.who = owner; r.rdata = '0; r.err = 1'b1; r.to = 1'b1;
                    resp_q.push_back(r);
                    prev_end  = 1'b1;
                    late_flag = 1'b1;
                end
            end else begin
                // Late or stray responses while idle must be dropped.
                if (late_flag || $urandom_range(0, 3) == 0) begin
                    m_ready_i = 1'b1;
                    m_err_i   = 1'($urandom);
                end
                late_flag = 1'b0;
            end

            // Requesters: a finished requester may immediately ask again.
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 2) == 0) new_req(n);
            end
            drive_reqs();
        end

        @(negedge clk_i);
        #1;
        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("reset_exercised", 64'(rst_done), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
